// File: rtl/adder_sched.sv
// Two-requester adder scheduler: one 4-bit adder is reused once per nibble,
// LSB first. Requests are granted round-robin and answered with a valid/ready response.

module adder_1c (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carry
);
  assign {carry, sum} = 5'(a) + 5'(b) + 5'(cin);
endmodule

module adder_sched #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [4*NIBBLES-1:0]   req0_a,
  input  logic [4*NIBBLES-1:0]   req0_b,
  input  logic                   req0_cin,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [4*NIBBLES-1:0]   req1_a,
  input  logic [4*NIBBLES-1:0]   req1_b,
  input  logic                   req1_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [4*NIBBLES-1:0]   rsp_sum,
  output logic                   rsp_cout,
  output logic                   busy
);
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state, state_nx;
  logic [NIBBLES-1:0][3:0] a_q, b_q, res_q;
  logic                    carry_q;
  logic                    id_q;
  logic                    last_q;
  logic [KW-1:0]           k_q;
  logic                    grant, accept, last_nib;
  logic [3:0]              nib_a, nib_b, nib_sum;
  logic                    nib_co;

  // On a tie, favour the requester that did not win the previous acceptance.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_q;
    else                          grant = req1_valid;
  end

  assign last_nib = (k_q == KW'(NIBBLES - 1));
  assign nib_a    = a_q[k_q];
  assign nib_b    = b_q[k_q];

  adder_1c u_add (
    .a     (nib_a),
    .b     (nib_b),
    .cin   (carry_q),
    .sum   (nib_sum),
    .carry (nib_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid & ~grant;
        req1_ready = req1_valid & grant;
        accept     = req0_ready | req1_ready;
        if (accept) state_nx = CALC;
      end
      CALC: if (last_nib) state_nx = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      k_q     <= '0;
    end else if (accept) begin
      a_q     <= grant ? req1_a   : req0_a;
      b_q     <= grant ? req1_b   : req0_b;
      carry_q <= grant ? req1_cin : req0_cin;
      id_q    <= grant;
      last_q  <= grant;
      k_q     <= '0;
    end else if (state == CALC) begin
      res_q[k_q] <= nib_sum;
      carry_q    <= nib_co;
      k_q        <= k_q + KW'(1);
    end
  end

  assign rsp_sum  = res_q;
  assign rsp_cout = carry_q;
  assign rsp_id   = id_q;
  assign busy     = (state != IDLE);
endmodule

// File: tb/tb_adder_sched.sv
// Directed bench for adder_sched (NIBBLES=4): arithmetic, latency, arbitration,
// response back-pressure and mid-operation reset.

module tb_adder_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_cin = 1'b0, req1_cin = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_cout, busy;
  logic [15:0] rsp_sum;

  int n_cmp = 0;
  int n_bad = 0;

  adder_sched #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request, waits for its response, then completes the handshake.
  task automatic run_op(input bit id, input logic [15:0] a, input logic [15:0] b, input logic cin,
                        output logic [15:0] sum, output logic cout, output logic rid, output int lat);
    int w;
    if (!id) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
    else     begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
    #1;
    w = 0;
    while (!(id ? req1_ready : req0_ready) && w < 20) begin step(); w++; end
    step();
    if (!id) begin req0_valid = 1'b0; req0_a = 16'hDEAD; req0_b = 16'hBEEF; req0_cin = 1'b1; end
    else     begin req1_valid = 1'b0; req1_a = 16'hDEAD; req1_b = 16'hBEEF; req1_cin = 1'b1; end
    lat = 1;
    while (!rsp_valid && lat < 20) begin step(); lat++; end
    sum  = rsp_sum;
    cout = rsp_cout;
    rid  = rsp_id;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (rsp_sum !== 16'h0000) begin n_bad++; $display("FAIL reset_sum got %h want 0000", rsp_sum); end
    n_cmp++; if ({rsp_cout, rsp_id} !== 2'b00) begin n_bad++; $display("FAIL reset_cout_id got %b want 00", {rsp_cout, rsp_id}); end
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [15:0] s; logic c, id; int lat;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h4321; req0_cin = 1'b0;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready got %b want 1", req0_ready); end
    step();
    n_cmp++; if ({req0_ready, busy} !== 2'b01) begin n_bad++; $display("FAIL basic_calc_ready_busy got %b want 01", {req0_ready, busy}); end
    req0_valid = 1'b0; req0_a = 16'hFFFF; req0_b = 16'hFFFF; req0_cin = 1'b1;
    lat = 1;
    while (!rsp_valid && lat < 20) begin step(); lat++; end
    s = rsp_sum; c = rsp_cout; id = rsp_id;
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL basic_latency got %0d want 5", lat); end
    n_cmp++; if (s !== 16'h5555) begin n_bad++; $display("FAIL basic_sum got %h want 5555", s); end
    n_cmp++; if ({c, id} !== 2'b00) begin n_bad++; $display("FAIL basic_cout_id got %b want 00", {c, id}); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL basic_after_hs got %b want 00", {rsp_valid, busy}); end
  endtask

  task automatic test_carry();
    logic [15:0] s; logic c, id; int lat;
    run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, s, c, id, lat);
    n_cmp++; if (s !== 16'h0000) begin n_bad++; $display("FAIL carry1_sum got %h want 0000", s); end
    n_cmp++; if ({c, id} !== 2'b11) begin n_bad++; $display("FAIL carry1_cout_id got %b want 11", {c, id}); end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL carry1_latency got %0d want 5", lat); end
    run_op(1'b1, 16'hFFFF, 16'h0000, 1'b1, s, c, id, lat);
    n_cmp++; if (s !== 16'h0000) begin n_bad++; $display("FAIL carry2_sum got %h want 0000", s); end
    n_cmp++; if ({c, id} !== 2'b11) begin n_bad++; $display("FAIL carry2_cout_id got %b want 11", {c, id}); end
  endtask

  task automatic test_arbitration();
    logic        ids [4];
    logic [15:0] sums [4];
    int nresp, cyc;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0010; req1_b = 16'h0020; req1_cin = 1'b0;
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL arb_first_grant got %b want 10", {req0_ready, req1_ready}); end
    nresp = 0; cyc = 0;
    while (nresp < 4 && cyc < 100) begin
      step(); cyc++;
      if (rsp_valid) begin ids[nresp] = rsp_id; sums[nresp] = rsp_sum; nresp++; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    rsp_ready = 1'b0;
    n_cmp++; if (nresp !== 4) begin n_bad++; $display("FAIL arb_resp_count got %0d want 4", nresp); end
    for (int i = 0; i < nresp; i++) begin
      n_cmp++; if (ids[i] !== i[0]) begin n_bad++; $display("FAIL arb_id[%0d] got %b want %b", i, ids[i], i[0]); end
      n_cmp++; if (sums[i] !== (i[0] ? 16'h0030 : 16'h0003)) begin n_bad++; $display("FAIL arb_sum[%0d] got %h want %h", i, sums[i], i[0] ? 16'h0030 : 16'h0003); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0;
    rsp_ready = 1'b0;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_idle got %b want 1", req0_ready); end
    step();
    req0_a = 16'h0005; req0_b = 16'h0006;
    lat = 1;
    while (!rsp_valid && lat < 20) begin step(); lat++; end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL bp_latency got %0d want 5", lat); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({rsp_valid, req0_ready, rsp_id} !== 3'b100) begin n_bad++; $display("FAIL bp_hold_ctrl[%0d] got %b want 100", i, {rsp_valid, req0_ready, rsp_id}); end
      n_cmp++; if ({rsp_cout, rsp_sum} !== 17'h03333) begin n_bad++; $display("FAIL bp_hold_sum[%0d] got %h want 03333", i, {rsp_cout, rsp_sum}); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if ({rsp_valid, req0_ready} !== 2'b10) begin n_bad++; $display("FAIL bp_hs_cycle got %b want 10", {rsp_valid, req0_ready}); end
    step();
    rsp_ready = 1'b0;
    #1;
    n_cmp++; if ({rsp_valid, busy, req0_ready} !== 3'b001) begin n_bad++; $display("FAIL bp_idle_cycle got %b want 001", {rsp_valid, busy, req0_ready}); end
    step();
    n_cmp++; if ({busy, req0_ready} !== 2'b10) begin n_bad++; $display("FAIL bp_second_accept got %b want 10", {busy, req0_ready}); end
    req0_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin step(); lat++; end
    n_cmp++; if (rsp_sum !== 16'h000B) begin n_bad++; $display("FAIL bp_second_sum got %h want 000b", rsp_sum); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; logic c, id; int lat, seen;
    req0_valid = 1'b1; req0_a = 16'h8888; req0_b = 16'h8888; req0_cin = 1'b0;
    #1;
    step();
    req0_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b0000) begin n_bad++; $display("FAIL midrst_ctrl got %b want 0000", {rsp_valid, busy, req0_ready, req1_ready}); end
    n_cmp++; if ({rsp_cout, rsp_sum} !== 17'h00000) begin n_bad++; $display("FAIL midrst_sum got %h want 00000", {rsp_cout, rsp_sum}); end
    seen = 0;
    repeat (10) begin step(); if (rsp_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_rsp got %0d want 0", seen); end
    run_op(1'b0, 16'h0F0F, 16'h00F1, 1'b0, s, c, id, lat);
    n_cmp++; if (s !== 16'h1000) begin n_bad++; $display("FAIL midrst_next_sum got %h want 1000", s); end
    n_cmp++; if ({c, id} !== 2'b00) begin n_bad++; $display("FAIL midrst_next_cout_id got %b want 00", {c, id}); end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL midrst_next_latency got %0d want 5", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
